// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StMode,
      StWr,
      StGo,
      StWlock,
      StDone,
      StPrst
   } state_e;

   localparam logic [5:0]  REG_MODE     = 6'h00;
   localparam logic [5:0]  REG_START    = 6'h02;
   localparam logic [31:0] MODE_WAITREQ = 32'h0;
   localparam logic [31:0] START_GO     = 32'h1;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } entry_t;

endpackage

// File: rtl/pll_lock_mon.sv
// PLL lock monitor: 2-flop synchroniser, saturating stable-lock counter and lock-loss edge detect.
module pll_lock_mon #(
   parameter int unsigned LOCK_STABLE = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic locked_i,
   input  logic clr_i,
   output logic stable_o,
   output logic fall_o
);
   localparam int unsigned CW = $clog2(LOCK_STABLE + 1);

   // [1:0] synchroniser, [2] previous synced value for edge detect
   logic [2:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[1:0], locked_i};
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(LOCK_STABLE)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign stable_o = (cnt_q == CW'(LOCK_STABLE));
   assign fall_o   = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: buffered Avalon-MM write table, start trigger, lock wait and
// lock-loss recovery. Define PLL_RECFG_TIMEOUT_EN to enable the WLOCK timeout and err flag.
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned LOCK_STABLE = 1024,
`ifdef PLL_RECFG_TIMEOUT_EN
   parameter int unsigned TIMEOUT     = 1048576,
`endif
   parameter int unsigned RST_CYCLES  = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cfg_we_i,
   input  logic [5:0]  cfg_addr_i,
   input  logic [31:0] cfg_data_i,
   input  logic        cfg_clear_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        ovf_o,
   output logic [5:0]  mgmt_address_o,
   output logic [31:0] mgmt_writedata_o,
   output logic        mgmt_write_o,
   input  logic        mgmt_waitrequest_i,
   input  logic        pll_locked_i,
   output logic        pll_rst_o,
   output logic        lock_ok_o
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned RW = $clog2(RST_CYCLES + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          recover_q, recover_d;
   logic          err_q, err_d;
   logic          ovf_q, ovf_d;
   logic          lock_stable, lock_fall, lock_clr;
   logic          full, table_we;
   entry_t        tbl_q [DEPTH];
   entry_t        cur;
`ifdef PLL_RECFG_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_q, tmo_d;
`endif

   pll_lock_mon #(
      .LOCK_STABLE(LOCK_STABLE)
   ) u_lock_mon (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .locked_i(pll_locked_i),
      .clr_i   (lock_clr),
      .stable_o(lock_stable),
      .fall_o  (lock_fall)
   );

   assign full     = (count_q == CW'(DEPTH));
   assign table_we = (state_q == StIdle) && cfg_we_i && !cfg_clear_i && !full;
   assign cur      = tbl_q[idx_q];

   always_ff @(posedge clk_i) begin
      if (table_we) begin
         tbl_q[count_q[IW-1:0]] <= {cfg_addr_i, cfg_data_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         count_q   <= '0;
         idx_q     <= '0;
         rcnt_q    <= '0;
         recover_q <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef PLL_RECFG_TIMEOUT_EN
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         rcnt_q    <= rcnt_d;
         recover_q <= recover_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
`ifdef PLL_RECFG_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      count_d          = count_q;
      idx_d            = idx_q;
      rcnt_d           = rcnt_q;
      recover_d        = recover_q;
      err_d            = err_q;
      ovf_d            = ovf_q;
      lock_clr         = 1'b0;
      mgmt_write_o     = 1'b0;
      mgmt_address_o   = '0;
      mgmt_writedata_o = '0;
      done_o           = 1'b0;
      pll_rst_o        = 1'b0;
`ifdef PLL_RECFG_TIMEOUT_EN
      tmo_cnt_d        = '0;
      tmo_d            = tmo_q;
`endif

      if (state_q == StIdle) begin
         if (cfg_clear_i) begin
            count_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
         end else if (cfg_we_i) begin
            if (full) ovf_d = 1'b1;
            else      count_d = count_q + CW'(1);
         end
      end

      case (state_q)
         StIdle: begin
            // Lock loss takes priority over a coincident start request
            if (lock_fall) begin
               state_d   = StPrst;
               recover_d = 1'b1;
               rcnt_d    = '0;
`ifdef PLL_RECFG_TIMEOUT_EN
               tmo_d     = 1'b0;
`endif
            end else if (start_i) begin
               state_d   = StMode;
               recover_d = 1'b0;
               err_d     = 1'b0;
`ifdef PLL_RECFG_TIMEOUT_EN
               tmo_d     = 1'b0;
`endif
            end
         end
         StMode: begin
            mgmt_write_o     = 1'b1;
            mgmt_address_o   = REG_MODE;
            mgmt_writedata_o = MODE_WAITREQ;
            if (!mgmt_waitrequest_i) begin
               idx_d   = '0;
               state_d = (count_q == '0) ? StGo : StWr;
            end
         end
         StWr: begin
            mgmt_write_o     = 1'b1;
            mgmt_address_o   = cur.addr;
            mgmt_writedata_o = cur.data;
            if (!mgmt_waitrequest_i) begin
               if (CW'(idx_q) + CW'(1) == count_q) state_d = StGo;
               else                                 idx_d   = idx_q + IW'(1);
            end
         end
         StGo: begin
            mgmt_write_o     = 1'b1;
            mgmt_address_o   = REG_START;
            mgmt_writedata_o = START_GO;
            if (!mgmt_waitrequest_i) begin
               lock_clr = 1'b1;
               state_d  = StWlock;
            end
         end
         StWlock: begin
            if (lock_stable) begin
               state_d = recover_q ? StIdle : StDone;
            end
`ifdef PLL_RECFG_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               err_d = 1'b1;
               if (tmo_q) begin
                  state_d = StIdle;
               end else begin
                  tmo_d   = 1'b1;
                  rcnt_d  = '0;
                  state_d = StPrst;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
`endif
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         StPrst: begin
            // Lock seen while the PLL is held in reset is meaningless
            pll_rst_o = 1'b1;
            lock_clr  = 1'b1;
            if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = StWlock;
            else                               rcnt_d  = rcnt_q + RW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy_o    = (state_q != StIdle);
   assign err_o     = err_q;
   assign ovf_o     = ovf_q;
   assign lock_ok_o = lock_stable && (state_q == StIdle);

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed self-checking bench for pll_reconfig_seq.
module tb_pll_reconfig_seq;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LS    = 1024;
   localparam int unsigned RC    = 16;
`ifdef PLL_RECFG_TIMEOUT_EN
   localparam int unsigned TMO   = 4096;
`endif

   logic        clk, rst_n, cfg_we, cfg_clear, start;
   logic [5:0]  cfg_addr, mgmt_address;
   logic [31:0] cfg_data, mgmt_writedata;
   logic        busy, done, err, ovf, mgmt_write, mgmt_waitrequest, pll_locked, pll_rst, lock_ok;

   int          checks, failures, done_cnt, rst_cnt;
   bit          lock_ok_seen;
   logic [37:0] wlog [$];

   pll_reconfig_seq #(
      .DEPTH      (DEPTH),
      .LOCK_STABLE(LS),
`ifdef PLL_RECFG_TIMEOUT_EN
      .TIMEOUT    (TMO),
`endif
      .RST_CYCLES (RC)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .cfg_we_i          (cfg_we),
      .cfg_addr_i        (cfg_addr),
      .cfg_data_i        (cfg_data),
      .cfg_clear_i       (cfg_clear),
      .start_i           (start),
      .busy_o            (busy),
      .done_o            (done),
      .err_o             (err),
      .ovf_o             (ovf),
      .mgmt_address_o    (mgmt_address),
      .mgmt_writedata_o  (mgmt_writedata),
      .mgmt_write_o      (mgmt_write),
      .mgmt_waitrequest_i(mgmt_waitrequest),
      .pll_locked_i      (pll_locked),
      .pll_rst_o         (pll_rst),
      .lock_ok_o         (lock_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mgmt_write && !mgmt_waitrequest) wlog.push_back({mgmt_address, mgmt_writedata});
         if (done) done_cnt++;
         if (pll_rst) rst_cnt++;
         if (lock_ok) lock_ok_seen = 1'b1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      cyc(1);
      cfg_we = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < limit) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      cyc(3);
      @(negedge clk);
      checks++;
      if ({busy, done, err, ovf, mgmt_write, pll_rst, lock_ok, mgmt_address, mgmt_writedata}
          !== 45'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b/%b %h %h want all zero", busy, done,
                  err, ovf, mgmt_write, pll_rst, lock_ok, mgmt_address, mgmt_writedata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      while (lock_ok !== 1'b1 && n < LS + 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < LS || n > LS + 4) begin
         failures++;
         $display("FAIL powerup_lock_ok_latency: got %0d cycles want %0d..%0d", n, LS, LS + 4);
      end
      cyc(1);
   endtask

   task automatic test_basic();
      logic [37:0] exp [5];
      int lat;
      exp[0] = {6'h00, 32'h0000_0000};
      exp[1] = {6'h04, 32'h0000_0404};
      exp[2] = {6'h03, 32'h0001_0505};
      exp[3] = {6'h07, 32'h5A5A_0000};
      exp[4] = {6'h02, 32'h0000_0001};
      push(6'h04, 32'h0000_0404);
      push(6'h03, 32'h0001_0505);
      push(6'h07, 32'h5A5A_0000);
      checks++;
      if (lock_ok !== 1'b1) begin
         failures++;
         $display("FAIL basic_lock_ok_idle: got %b want 1", lock_ok);
      end
      wlog.delete(); done_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      checks++;
      if (busy !== 1'b1 || lock_ok !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy: got busy=%b lock_ok=%b want 1/0", busy, lock_ok);
      end
      wait_done(LS + 200, lat);
      checks++;
      if (lat < LS + 5 || lat > LS + 9) begin
         failures++;
         $display("FAIL basic_done_latency: got %0d want %0d..%0d", lat, LS + 5, LS + 9);
      end
      cyc(10);
      checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_once: got done_cnt=%0d busy=%b want 1/0", done_cnt, busy);
      end
      checks++;
      if (wlog.size() != 5) begin
         failures++;
         $display("FAIL basic_write_count: got %0d want 5", wlog.size());
      end
      for (int i = 0; i < 5; i++) begin
         logic [37:0] got;
         got = (i < wlog.size()) ? wlog[i] : 38'bx;
         checks++;
         if (got !== exp[i]) begin
            failures++;
            $display("FAIL basic_write%0d: got %h want %h", i, got, exp[i]);
         end
      end
   endtask

   task automatic test_waitreq_stall();
      logic [37:0] exp [5];
      int lat, bad;
      exp[0] = {6'h00, 32'h0000_0000};
      exp[1] = {6'h04, 32'h0000_0404};
      exp[2] = {6'h03, 32'h0001_0505};
      exp[3] = {6'h07, 32'h5A5A_0000};
      exp[4] = {6'h02, 32'h0000_0001};
      wlog.delete(); done_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      mgmt_waitrequest = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({mgmt_write, mgmt_address, mgmt_writedata} !== {1'b1, 6'h04, 32'h0000_0404}) begin
            failures++;
            $display("FAIL stall_hold%0d: got %b %h %h want 1 04 00000404", k, mgmt_write,
                     mgmt_address, mgmt_writedata);
         end
         @(posedge clk); #1;
      end
      mgmt_waitrequest = 1'b0;
      wait_done(LS + 200, lat);
      cyc(10);
      bad = 0;
      for (int i = 0; i < 5; i++) if (i >= wlog.size() || wlog[i] !== exp[i]) bad++;
      checks++;
      if (wlog.size() != 5 || bad != 0 || done_cnt != 1) begin
         failures++;
         $display("FAIL stall_writes: got count=%0d bad=%0d done_cnt=%0d want 5/0/1", wlog.size(),
                  bad, done_cnt);
      end
   endtask

   task automatic test_overflow();
      int lat, bad;
      cfg_clear = 1'b1; cyc(1); cfg_clear = 1'b0;
      for (int i = 0; i < 8; i++) push(6'(8 + i), 32'hA000_0000 + 32'(i));
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_at_full: got %b want 0", ovf);
      end
      push(6'h3F, 32'hFFFF_FFFF);
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: got %b want 1", ovf);
      end
      wlog.delete(); done_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      wait_done(LS + 200, lat);
      cyc(5);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         logic [37:0] e;
         if (i == 0)      e = {6'h00, 32'h0};
         else if (i == 9) e = {6'h02, 32'h1};
         else             e = {6'(8 + i - 1), 32'hA000_0000 + 32'(i - 1)};
         if (i >= wlog.size() || wlog[i] !== e) bad++;
      end
      checks++;
      if (wlog.size() != 10 || bad != 0) begin
         failures++;
         $display("FAIL ovf_writes: got count=%0d bad=%0d want 10/0", wlog.size(), bad);
      end
      // clear and push together: clear must win
      cfg_clear = 1'b1; cfg_we = 1'b1; cfg_addr = 6'h11; cfg_data = 32'hDEAD_BEEF;
      cyc(1);
      cfg_clear = 1'b0; cfg_we = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got %b want 0", ovf);
      end
      wlog.delete(); done_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      wait_done(LS + 200, lat);
      cyc(5);
      checks++;
      if (wlog.size() != 2 || wlog[0] !== {6'h00, 32'h0} || wlog[1] !== {6'h02, 32'h1}) begin
         failures++;
         $display("FAIL clear_empty_table: got count=%0d want 2 (00,02)", wlog.size());
      end
   endtask

   task automatic test_lock_loss();
      int n;
      bit sb;
      checks++;
      if (lock_ok !== 1'b1) begin
         failures++;
         $display("FAIL loss_lock_ok_pre: got %b want 1", lock_ok);
      end
      rst_cnt = 0; done_cnt = 0; sb = 1'b0; n = 0;
      pll_locked = 1'b0; cyc(3); pll_locked = 1'b1;
      while (n < LS + 300) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) sb = 1'b1;
         else if (sb) break;
      end
      checks++;
      if (sb !== 1'b1 || busy !== 1'b0 || lock_ok !== 1'b1) begin
         failures++;
         $display("FAIL loss_recover: got seen_busy=%b busy=%b lock_ok=%b want 1/0/1", sb, busy,
                  lock_ok);
      end
      checks++;
      if (rst_cnt != RC) begin
         failures++;
         $display("FAIL loss_rst_width: got %0d want %0d", rst_cnt, RC);
      end
      checks++;
      if (done_cnt != 0) begin
         failures++;
         $display("FAIL loss_no_done: got %0d want 0", done_cnt);
      end
      cyc(1);
   endtask

   task automatic test_lock_bounce();
      int lat, nt;
`ifdef PLL_RECFG_TIMEOUT_EN
      nt = 90;
`else
      nt = 20;
`endif
      done_cnt = 0; rst_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(2);
      lock_ok_seen = 1'b0;
      for (int k = 0; k < nt; k++) begin
         cyc(100);
         pll_locked = ~pll_locked;
      end
      checks++;
      if (lock_ok_seen !== 1'b0 || done_cnt != 0) begin
         failures++;
         $display("FAIL bounce_no_lock: got lock_ok_seen=%b done_cnt=%0d want 0/0", lock_ok_seen,
                  done_cnt);
      end
`ifdef PLL_RECFG_TIMEOUT_EN
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL bounce_timeout_err: got %b want 1", err);
      end
      pll_locked = 1'b1;
      lat = 0;
      while (busy === 1'b1 && lat < LS + TMO + 200) begin
         @(negedge clk);
         lat++;
      end
      cyc(1);
`else
      checks++;
      if (err !== 1'b0 || rst_cnt != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL bounce_wait: got err=%b rst_cnt=%0d busy=%b want 0/0/1", err, rst_cnt,
                  busy);
      end
      pll_locked = 1'b1;
      wait_done(LS + 200, lat);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL bounce_relock_done: got done=%b after %0d cycles want 1", done, lat);
      end
      cyc(2);
`endif
   endtask

   task automatic test_async_reset();
      int lat;
      cfg_clear = 1'b1; cyc(1); cfg_clear = 1'b0;
      push(6'h04, 32'h0000_0404);
      push(6'h03, 32'h0001_0505);
      push(6'h07, 32'h5A5A_0000);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      mgmt_waitrequest = 1'b1;
      cyc(2);
      checks++;
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'h04 || busy !== 1'b1) begin
         failures++;
         $display("FAIL arst_in_wr: got write=%b addr=%h busy=%b want 1/04/1", mgmt_write,
                  mgmt_address, busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, err, ovf, mgmt_write, pll_rst, lock_ok, mgmt_address, mgmt_writedata}
          !== 45'd0) begin
         failures++;
         $display("FAIL arst_outputs: got %b/%b/%b/%b/%b/%b/%b %h %h want all zero", busy, done,
                  err, ovf, mgmt_write, pll_rst, lock_ok, mgmt_address, mgmt_writedata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mgmt_waitrequest = 1'b0;
      wlog.delete(); done_cnt = 0;
      start = 1'b1; cyc(1); start = 1'b0;
      wait_done(LS + 200, lat);
      cyc(5);
      checks++;
      if (wlog.size() != 2 || wlog[0] !== {6'h00, 32'h0} || wlog[1] !== {6'h02, 32'h1} ||
          done_cnt != 1) begin
         failures++;
         $display("FAIL arst_empty_run: got count=%0d done_cnt=%0d want 2 writes (00,02) 1 done",
                  wlog.size(), done_cnt);
      end
   endtask

   initial begin
      checks = 0; failures = 0; done_cnt = 0; rst_cnt = 0; lock_ok_seen = 1'b0;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_clear = 1'b0; start = 1'b0;
      cfg_addr = '0; cfg_data = '0; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
      test_reset();
      test_basic();
      test_waitreq_stall();
      test_overflow();
      test_lock_loss();
      test_lock_bounce();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
